av2_decode_sequencer: RTL and testbench
=======================================

# av2_decode_sequencer

Multi-channel frame sequencer for the AV2 decoder: arbitrates NUM_CH compressed-bitstream channels onto one shared OBU-parser / header-parser / tile-decoder / output-controller datapath. It runs one frame job at a time through the phase state machine. Each phase has a watchdog timeout. The block keeps per-channel frame and error counters and exposes them through a register port with maskable, write-1-to-clear interrupts. It sits between the AXI-Stream input mux and the decode engines, replacing the single-stream control FSM.

## Interface
- NUM_CH, 4: number of input channels, 1..16; CH_W = max(1, clog2(NUM_CH)).
- TIMEOUT_W, 24: watchdog counter / TIMEOUT register width.
- TIMEOUT_DEFAULT, 1000000: TIMEOUT register reset value.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ch_req  in  NUM_CH  channel i has stream data pending (its s_axis_tvalid).
- ch_grant  out  NUM_CH  one-hot owner of the datapath; 0 when idle.
- ch_sel  out  CH_W  binary index of the granted channel; holds its last value when idle.
- obu_valid  in  1  OBU parser reports a parsed OBU.
- obu_type  in  4  OBU type; sampled only with obu_valid.
- hdr_valid  in  1  frame header parsed.
- tile_start  out  1  one-cycle start pulse to the tile decoder.
- tile_done  in  1  tile decode complete.
- out_start  out  1  one-cycle start pulse to the output controller.
- out_done  in  1  frame output complete.
- obu_ready  out  1  high in PARSE_OBU.
- busy  out  1  state != IDLE, registered.
- reg_addr  in  16  register byte address.
- reg_wdata  in  32  write data.
- reg_wr_en  in  1  write strobe.
- reg_rd_en  in  1  read strobe.
- reg_rdata  out  32  read data; valid while reg_ready is high.
- reg_ready  out  1  registered acknowledge.
- irq_frame_done  out  1  level interrupt: IRQ_STATUS[0] & IRQ_MASK[0].
- irq_error  out  1  level interrupt: IRQ_STATUS[1] & IRQ_MASK[1].

## Operation
- States: IDLE, PARSE_OBU, PARSE_HEADER, DECODE_TILES, OUTPUT, ERROR.
- Grant arbitration:
  - Eligible channels are ch_req & CTRL.ch_enable.
  - In IDLE with any channel eligible, grant goes round-robin starting at last_grant+1 (mod NUM_CH). last_grant resets to NUM_CH-1, so channel 0 wins first.
  - The grant is registered and the FSM moves to PARSE_OBU.
  - The grant is held until the FSM returns to IDLE. ch_req changes mid-job are ignored.
- PARSE_OBU transitions on obu_valid:
  - type 1 → IDLE (no frame counted).
  - type 3 → PARSE_HEADER.
  - type 6 → DECODE_TILES.
  - any other type → IDLE.
- PARSE_HEADER: hdr_valid → DECODE_TILES.
- DECODE_TILES: tile_done → OUTPUT.
- OUTPUT: out_done → IDLE. On this transition, frames_decoded[ch_sel] += 1 and IRQ_STATUS[0] is set.
- Watchdog:
  - Counter clears on every state entry and increments each cycle in any non-IDLE, non-ERROR state.
  - When it equals TIMEOUT (nonzero) → ERROR. TIMEOUT = 0 disables the watchdog.
  - A done/valid input arriving in the same cycle as timeout wins; there is no error.
- ERROR lasts exactly one cycle: error_count[ch_sel] += 1, IRQ_STATUS[1] set, then → IDLE and grant released.
- Clearing the channel's ch_enable bit mid-job does not abort the job.
- Counters are 32-bit and wrap to 0.
- Registers (unmapped reads return 0xDEADBEEF; unmapped writes are ignored):
  - 0x000 ID: 0x41563201, read-only.
  - 0x004 CTRL: [NUM_CH-1:0] ch_enable, reset all ones.
  - 0x008 STATUS, read-only: [0] busy, [7:4] state, [15:8] ch_sel.
  - 0x00C IRQ_STATUS: [1:0], write-1-to-clear. A hardware set in the same cycle as a clear wins.
  - 0x010 IRQ_MASK: [1:0], reset 2'b11.
  - 0x014 TIMEOUT: [TIMEOUT_W-1:0].
  - 0x100+8*i frames_decoded[i], 0x104+8*i error_count[i]; read-only.
- Simultaneous reg_rd_en and reg_wr_en: the write is performed and the read returns the pre-write value.
- State encoding in STATUS[7:4]: IDLE=0, PARSE_OBU=1, PARSE_HEADER=2, DECODE_TILES=3, OUTPUT=4, ERROR=7.

## Timing
- Reset (rst_n low at a clock edge):
  - Outputs: state IDLE, ch_grant 0, ch_sel 0, tile_start/out_start 0, busy 0, reg_rdata 0, reg_ready 0, irqs 0.
  - All counters 0 and IRQ_STATUS 0.
  - Reset mid-job aborts the job without counting an error.
- Grant latency: ch_req sampled high in IDLE at edge N gives ch_grant, obu_ready and busy high after edge N+1.
- tile_start is high for exactly the first cycle in DECODE_TILES; out_start for exactly the first cycle in OUTPUT. They are registered from the entry transition.
- Register access: reg_ready and reg_rdata appear one cycle after the strobe, for one cycle per strobe. Back-to-back strobes are accepted every cycle.
- A register write takes effect on the edge that samples the strobe.
- Minimum job length: type-6 path with same-cycle dones takes 4 cycles from grant to IDLE.
- A new grant may occur on the cycle after returning to IDLE.

## Test plan
- Single frame: ch_req=4'b0001, obu_type=6, tile_done after 10 cycles, out_done after 5 → tile_start/out_start one cycle each; frames_decoded[0]=1; irq_frame_done=1; writing 0x1 to 0x00C clears it.
- Round-robin: ch_req=4'b1111 held for 4 jobs → grant order 0,1,2,3, then 0 again.
- Watchdog: TIMEOUT=20, tile_done never asserted → ERROR 20 cycles after entering DECODE_TILES; error_count[ch]=1; irq_error=1; grant released.
- Masking and enable: IRQ_MASK=0 → irq outputs stay 0 while IRQ_STATUS still sets. CTRL=4'b1110 with ch_req=4'b0001 → no grant.
- Register edges: read 0x000 → 0x41563201 one cycle later; read 0x0F0 → 0xDEADBEEF; W1C write colliding with an out_done set → bit remains 1.
- Reset mid-DECODE_TILES: rst_n low for 1 cycle → IDLE, counters 0, no error counted.

Source files
------------

// File: rtl/av2_decode_sequencer.sv
// av2_decode_sequencer: frame-level control for the shared AV2 decode datapath.
// Grants one of NUM_CH input channels round-robin, walks the frame job through
// OBU parse, header parse, tile decode and output phases with a per-phase
// watchdog, and exposes ID/control/status/interrupt and per-channel counters
// through a simple strobe-based register port.
module av2_decode_sequencer #(
    parameter int NUM_CH          = 4,
    parameter int TIMEOUT_W       = 24,
    parameter int TIMEOUT_DEFAULT = 1000000,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_grant,
    output logic [CH_W-1:0]   ch_sel,
    input  logic              obu_valid,
    input  logic [3:0]        obu_type,
    input  logic              hdr_valid,
    output logic              tile_start,
    input  logic              tile_done,
    output logic              out_start,
    input  logic              out_done,
    output logic              obu_ready,
    output logic              busy,
    input  logic [15:0]       reg_addr,
    input  logic [31:0]       reg_wdata,
    input  logic              reg_wr_en,
    input  logic              reg_rd_en,
    output logic [31:0]       reg_rdata,
    output logic              reg_ready,
    output logic              irq_frame_done,
    output logic              irq_error
);

    localparam logic [31:0] ID_VALUE = 32'h4156_3201;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PARSE_OBU    = 3'd1,
        PARSE_HEADER = 3'd2,
        DECODE_TILES = 3'd3,
        OUTPUT       = 3'd4,
        ERROR        = 3'd7
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       rr_idx;
    logic                  rr_found;
    logic [NUM_CH-1:0]     eligible;
    logic [TIMEOUT_W-1:0]  wd_cnt;
    logic                  wd_expired;
    logic                  frame_set;
    logic                  err_set;

    logic [NUM_CH-1:0]     ch_enable;
    logic [1:0]            irq_status;
    logic [1:0]            irq_mask;
    logic [1:0]            irq_set;
    logic [1:0]            irq_clr;
    logic [TIMEOUT_W-1:0]  timeout_reg;
    logic [31:0]           frames_decoded [NUM_CH];
    logic [31:0]           error_count    [NUM_CH];

    logic [15:0]           ch_off;
    logic                  ch_hit;
    logic [CH_W-1:0]       ch_idx;
    logic [31:0]           rd_val;
    logic                  unused_wdata;

    assign eligible   = ch_req & ch_enable;
    // Expiry is judged on the count the counter is about to reach, so a phase
    // entered at edge E0 errors out at edge E0+TIMEOUT.
    assign wd_expired = (timeout_reg != '0) && ((wd_cnt + TIMEOUT_W'(1)) == timeout_reg);
    assign frame_set  = (state == OUTPUT) && out_done;
    assign err_set    = (state == ERROR);
    assign irq_set    = {err_set, frame_set};
    assign irq_clr    = (reg_wr_en && reg_addr == 16'h000C) ? reg_wdata[1:0] : 2'b00;

    assign irq_frame_done = irq_status[0] & irq_mask[0];
    assign irq_error      = irq_status[1] & irq_mask[1];

    assign ch_off       = reg_addr - 16'h0100;
    assign ch_hit       = (reg_addr >= 16'h0100) && (ch_off < 16'(8 * NUM_CH)) && (ch_off[1:0] == 2'b00);
    assign ch_idx       = ch_off[CH_W+2:3];
    assign unused_wdata = ^reg_wdata;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!rr_found && eligible[(int'(last_grant) + k) % NUM_CH]) begin
                rr_found = 1'b1;
                rr_idx   = CH_W'((int'(last_grant) + k) % NUM_CH);
            end
        end
    end

    // Next-state logic; a completing input beats a same-cycle watchdog expiry.
    always_comb begin
        state_nxt = state;
        obu_ready = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) state_nxt = PARSE_OBU;
            end
            PARSE_OBU: begin
                obu_ready = 1'b1;
                if (obu_valid) begin
                    case (obu_type)
                        4'd3:    state_nxt = PARSE_HEADER;
                        4'd6:    state_nxt = DECODE_TILES;
                        default: state_nxt = IDLE;
                    endcase
                end else if (wd_expired) begin
                    state_nxt = ERROR;
                end
            end
            PARSE_HEADER: begin
                if (hdr_valid)       state_nxt = DECODE_TILES;
                else if (wd_expired) state_nxt = ERROR;
            end
            DECODE_TILES: begin
                if (tile_done)       state_nxt = OUTPUT;
                else if (wd_expired) state_nxt = ERROR;
            end
            OUTPUT: begin
                if (out_done)        state_nxt = IDLE;
                else if (wd_expired) state_nxt = ERROR;
            end
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, grant ownership, start pulses and watchdog counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_grant   <= '0;
            ch_sel     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            busy       <= 1'b0;
            tile_start <= 1'b0;
            out_start  <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            tile_start <= (state_nxt == DECODE_TILES) && (state != DECODE_TILES);
            out_start  <= (state_nxt == OUTPUT) && (state != OUTPUT);
            if (state == IDLE && state_nxt == PARSE_OBU) begin
                ch_grant   <= NUM_CH'(1) << rr_idx;
                ch_sel     <= rr_idx;
                last_grant <= rr_idx;
            end else if (state_nxt == IDLE) begin
                ch_grant <= '0;
            end
            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if (state != IDLE && state != ERROR) begin
                wd_cnt <= wd_cnt + TIMEOUT_W'(1);
            end
        end
    end

    // Per-channel frame and error counters, charged to the owning channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                frames_decoded[i] <= '0;
                error_count[i]    <= '0;
            end
        end else begin
            if (frame_set) frames_decoded[ch_sel] <= frames_decoded[ch_sel] + 32'd1;
            if (err_set)   error_count[ch_sel]    <= error_count[ch_sel] + 32'd1;
        end
    end

    // Writable registers; a hardware interrupt set overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_enable   <= '1;
            irq_status  <= 2'b00;
            irq_mask    <= 2'b11;
            timeout_reg <= TIMEOUT_W'(TIMEOUT_DEFAULT);
        end else begin
            irq_status <= (irq_status & ~irq_clr) | irq_set;
            if (reg_wr_en) begin
                case (reg_addr)
                    16'h0004: ch_enable   <= reg_wdata[NUM_CH-1:0];
                    16'h0010: irq_mask    <= reg_wdata[1:0];
                    16'h0014: timeout_reg <= reg_wdata[TIMEOUT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read mux over current (pre-write) register values.
    always_comb begin
        rd_val = 32'hDEAD_BEEF;
        case (reg_addr)
            16'h0000: rd_val = ID_VALUE;
            16'h0004: begin
                rd_val                 = '0;
                rd_val[NUM_CH-1:0]     = ch_enable;
            end
            16'h0008: rd_val = {16'd0, 8'(ch_sel), 1'b0, state, 3'b000, busy};
            16'h000C: rd_val = {30'd0, irq_status};
            16'h0010: rd_val = {30'd0, irq_mask};
            16'h0014: begin
                rd_val                 = '0;
                rd_val[TIMEOUT_W-1:0]  = timeout_reg;
            end
            default: begin
                if (ch_hit) rd_val = ch_off[2] ? error_count[ch_idx] : frames_decoded[ch_idx];
            end
        endcase
    end

    // Register port acknowledge and read data, one cycle after each strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_ready <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ready <= reg_rd_en | reg_wr_en;
            reg_rdata <= reg_rd_en ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_av2_decode_sequencer.sv
// Testbench for av2_decode_sequencer: register vector table plus directed
// frame-job sequences (single frame, round-robin, watchdog, masking, W1C race,
// reset mid-job).
module tb_av2_decode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_req;
    logic [3:0]  ch_grant;
    logic [1:0]  ch_sel;
    logic        obu_valid;
    logic [3:0]  obu_type;
    logic        hdr_valid;
    logic        tile_start;
    logic        tile_done;
    logic        out_start;
    logic        out_done;
    logic        obu_ready;
    logic        busy;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        irq_frame_done;
    logic        irq_error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } reg_vec_t;

    reg_vec_t vecs [19];

    av2_decode_sequencer #(
        .NUM_CH(4),
        .TIMEOUT_W(24),
        .TIMEOUT_DEFAULT(1000000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ch_req(ch_req),
        .ch_grant(ch_grant),
        .ch_sel(ch_sel),
        .obu_valid(obu_valid),
        .obu_type(obu_type),
        .hdr_valid(hdr_valid),
        .tile_start(tile_start),
        .tile_done(tile_done),
        .out_start(out_start),
        .out_done(out_done),
        .obu_ready(obu_ready),
        .busy(busy),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_rdata(reg_rdata),
        .reg_ready(reg_ready),
        .irq_frame_done(irq_frame_done),
        .irq_error(irq_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One strobe cycle; returns what the port shows after the sampling edge.
    task automatic reg_rw(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic ready);
        reg_rd_en = rd;
        reg_wr_en = wr;
        reg_addr  = addr;
        reg_wdata = wdata;
        tick();
        reg_rd_en = 1'b0;
        reg_wr_en = 1'b0;
        rdata     = reg_rdata;
        ready     = reg_ready;
    endtask

    task automatic reg_wr(input logic [15:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        r;
        reg_rw(1'b0, 1'b1, addr, wdata, d, r);
    endtask

    task automatic reg_rd_check(input string name, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        r;
        reg_rw(1'b1, 1'b0, addr, 32'd0, d, r);
        check(name, d, exp);
    endtask

    task automatic grant_ch(input logic [3:0] req);
        ch_req = req;
        tick();
        ch_req = 4'b0000;
    endtask

    task automatic send_obu(input logic [3:0] t);
        obu_valid = 1'b1;
        obu_type  = t;
        tick();
        obu_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] d;
        logic        r;
        logic [3:0]  rr_exp [5];
        int          n;

        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        //             rd    wr    addr      wdata         expected rdata
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'h41563201};
        vecs[1]  = '{1'b1, 1'b0, 16'h0004, 32'h0,        32'h0000000F};
        vecs[2]  = '{1'b1, 1'b0, 16'h0008, 32'h0,        32'h00000000};
        vecs[3]  = '{1'b1, 1'b0, 16'h000C, 32'h0,        32'h00000000};
        vecs[4]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'h00000003};
        vecs[5]  = '{1'b1, 1'b0, 16'h0014, 32'h0,        32'h000F4240};
        vecs[6]  = '{1'b1, 1'b0, 16'h00F0, 32'h0,        32'hDEADBEEF};
        vecs[7]  = '{1'b1, 1'b0, 16'h0100, 32'h0,        32'h00000000};
        vecs[8]  = '{1'b1, 1'b0, 16'h011C, 32'h0,        32'h00000000};
        vecs[9]  = '{1'b1, 1'b0, 16'h0120, 32'h0,        32'hDEADBEEF};
        vecs[10] = '{1'b1, 1'b0, 16'h0102, 32'h0,        32'hDEADBEEF};
        vecs[11] = '{1'b1, 1'b1, 16'h0014, 32'h30,       32'h000F4240};
        vecs[12] = '{1'b1, 1'b0, 16'h0014, 32'h0,        32'h00000030};
        vecs[13] = '{1'b0, 1'b1, 16'h0000, 32'h12345678, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'h41563201};
        vecs[15] = '{1'b0, 1'b1, 16'h0008, 32'hFFFFFFFF, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 16'h0008, 32'h0,        32'h00000000};
        vecs[17] = '{1'b0, 1'b1, 16'h0014, 32'h000F4240, 32'h0};
        vecs[18] = '{1'b1, 1'b0, 16'h0014, 32'h0,        32'h000F4240};

        rst_n = 1'b0; ch_req = '0; obu_valid = 1'b0; obu_type = '0; hdr_valid = 1'b0;
        tile_done = 1'b0; out_done = 1'b0; reg_addr = '0; reg_wdata = '0;
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_grant", 32'(ch_grant), 32'h0);
        check("rst_sel", 32'(ch_sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_starts", 32'({tile_start, out_start, obu_ready}), 32'h0);
        check("rst_reg", 32'({reg_ready, reg_rdata != 32'd0}), 32'h0);
        check("rst_irqs", 32'({irq_frame_done, irq_error}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Register vector table
        for (int i = 0; i < 19; i++) begin
            reg_rw(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, r);
            check($sformatf("regvec%0d_ready", i), 32'(r), 32'h1);
            if (vecs[i].rd) check($sformatf("regvec%0d_rdata", i), d, vecs[i].exp_rdata);
        end
        tick();
        check("reg_ready_one_cycle", 32'(reg_ready), 32'h0);

        // Single frame on channel 0
        grant_ch(4'b0001);
        check("sf_grant", 32'(ch_grant), 32'h1);
        check("sf_obu_ready", 32'(obu_ready), 32'h1);
        check("sf_busy", 32'(busy), 32'h1);
        reg_rd_check("sf_status", 16'h0008, 32'h00000011);
        send_obu(4'd6);
        check("sf_tile_start_hi", 32'(tile_start), 32'h1);
        check("sf_obu_ready_lo", 32'(obu_ready), 32'h0);
        tick();
        check("sf_tile_start_lo", 32'(tile_start), 32'h0);
        repeat (8) tick();
        tile_done = 1'b1; tick(); tile_done = 1'b0;
        check("sf_out_start_hi", 32'(out_start), 32'h1);
        tick();
        check("sf_out_start_lo", 32'(out_start), 32'h0);
        repeat (3) tick();
        out_done = 1'b1; tick(); out_done = 1'b0;
        check("sf_grant_released", 32'(ch_grant), 32'h0);
        check("sf_busy_lo", 32'(busy), 32'h0);
        check("sf_irq_frame", 32'({irq_frame_done, irq_error}), 32'h2);
        reg_rd_check("sf_frames0", 16'h0100, 32'd1);
        reg_rd_check("sf_errors0", 16'h0104, 32'd0);
        reg_wr(16'h000C, 32'h1);
        check("sf_irq_cleared", 32'(irq_frame_done), 32'h0);
        reg_rd_check("sf_irq_status", 16'h000C, 32'h0);

        // Round-robin after reset: 0,1,2,3,0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ch_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            tick();
            check($sformatf("rr_grant%0d", j), 32'(ch_grant), 32'(rr_exp[j]));
            send_obu(4'd1);
            check($sformatf("rr_release%0d", j), 32'(ch_grant), 32'h0);
        end
        ch_req = 4'b0000;
        reg_rd_check("rr_no_frames0", 16'h0100, 32'd0);
        reg_rd_check("rr_no_frames1", 16'h0108, 32'd0);

        // Watchdog: TIMEOUT=20 in DECODE_TILES on channel 2. ERROR is entered
        // 20 edges after the entry edge and lasts one cycle, so the grant
        // drops on the 21st edge.
        reg_wr(16'h0014, 32'd20);
        grant_ch(4'b0100);
        check("wd_grant", 32'(ch_grant), 32'h4);
        reg_rd_check("wd_status", 16'h0008, 32'h00000211);
        send_obu(4'd6);
        check("wd_tile_start", 32'(tile_start), 32'h1);
        n = 0;
        while (ch_grant != 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        check("wd_cycles_to_release", 32'(n), 32'd21);
        check("wd_irq_error", 32'(irq_error), 32'h1);
        check("wd_busy_lo", 32'(busy), 32'h0);
        reg_rd_check("wd_errors2", 16'h0114, 32'd1);
        reg_rd_check("wd_errors0", 16'h0104, 32'd0);

        // tile_done in the same cycle as expiry wins
        grant_ch(4'b1000);
        send_obu(4'd6);
        repeat (19) tick();
        tile_done = 1'b1; tick(); tile_done = 1'b0;
        check("wdr_out_start", 32'(out_start), 32'h1);
        out_done = 1'b1; tick(); out_done = 1'b0;
        check("wdr_grant_released", 32'(ch_grant), 32'h0);
        reg_rd_check("wdr_frames3", 16'h0118, 32'd1);
        reg_rd_check("wdr_errors3", 16'h011C, 32'd0);
        reg_wr(16'h000C, 32'h3);
        reg_wr(16'h0014, 32'd0);

        // Masked interrupts with a minimum-length job (4 cycles grant to IDLE)
        reg_wr(16'h0010, 32'h0);
        grant_ch(4'b0001);
        check("min_grant", 32'(ch_grant), 32'h1);
        send_obu(4'd6);
        tile_done = 1'b1; tick(); tile_done = 1'b0;
        out_done = 1'b1; tick(); out_done = 1'b0;
        check("min_idle", 32'({busy, ch_grant}), 32'h0);
        check("mask_irqs_lo", 32'({irq_frame_done, irq_error}), 32'h0);
        reg_rd_check("mask_status_set", 16'h000C, 32'h1);

        // Disabled channel gets no grant
        reg_wr(16'h0004, 32'hE);
        ch_req = 4'b0001;
        repeat (3) tick();
        check("en_no_grant", 32'({busy, ch_grant}), 32'h0);
        ch_req = 4'b0000;
        reg_wr(16'h0004, 32'hF);
        reg_wr(16'h0010, 32'h3);
        reg_wr(16'h000C, 32'h3);

        // W1C clear colliding with a hardware frame-done set
        grant_ch(4'b0010);
        send_obu(4'd6);
        tile_done = 1'b1; tick(); tile_done = 1'b0;
        out_done  = 1'b1;
        reg_wr_en = 1'b1; reg_addr = 16'h000C; reg_wdata = 32'h1;
        tick();
        out_done  = 1'b0; reg_wr_en = 1'b0;
        check("w1c_race_irq", 32'(irq_frame_done), 32'h1);
        reg_rd_check("w1c_race_status", 16'h000C, 32'h1);

        // Reset while in DECODE_TILES
        grant_ch(4'b0001);
        send_obu(4'd6);
        repeat (3) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rmid_idle", 32'({busy, ch_grant, tile_start}), 32'h0);
        check("rmid_irqs", 32'({irq_frame_done, irq_error}), 32'h0);
        reg_rd_check("rmid_frames0", 16'h0100, 32'd0);
        reg_rd_check("rmid_errors0", 16'h0104, 32'd0);
        reg_rd_check("rmid_irq_status", 16'h000C, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
